// File: rtl/uart_pkg.sv
// Shared UART datapath types: bit-timer mode/state encodings and default widths.
package uart_pkg;
  localparam int TMR_WIDTH_DEF = 16;
  localparam int TMR_PRE_W_DEF = 8;

  typedef enum logic {TMR_PERIODIC, TMR_ONESHOT} timer_mode_e;
  typedef enum logic {TMR_IDLE, TMR_RUN} timer_state_e;
endpackage

// File: rtl/tick_prescaler.sv
// Step-enable generator: divides clk by div+1 while enabled; clr restarts the phase.
module tick_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [PRE_W-1:0] div,
  output logic             step
);
  logic [PRE_W-1:0] cnt;

  assign step = en && (cnt == div);

  always_ff @(posedge clk) begin
    if (rst || clr)  cnt <= '0;
    else if (en)     cnt <= step ? '0 : cnt + PRE_W'(1);
  end
endmodule

// File: rtl/uart_bit_timer.sv
// Restartable bit-period timer: periodic or one-shot tick, centre-of-bit half_tick.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int WIDTH = TMR_WIDTH_DEF,
  parameter int PRE_W = TMR_PRE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  timer_mode_e       mode,
  input  logic [WIDTH-1:0]  period,
  input  logic [PRE_W-1:0]  prescale,
  output logic              busy,
  output logic              tick,
  output logic              half_tick,
  output logic              done,
  output logic [WIDTH-1:0]  count
);
  timer_state_e     state, state_d;
  timer_mode_e      mode_r;
  logic [WIDTH-1:0] period_r, count_d, last;
  logic [PRE_W-1:0] prescale_r;
  logic [WIDTH:0]   p_full, half_pt;
  logic             tick_d, half_d, done_d, load, pclr, step;

  // Period 0 stands for 2^WIDTH steps, so the half point needs one extra bit.
  assign p_full  = {period_r == '0, period_r};
  assign half_pt = p_full >> 1;
  assign last    = period_r - WIDTH'(1);
  assign busy    = (state == TMR_RUN);

  tick_prescaler #(.PRE_W(PRE_W)) u_pre (
    .clk  (clk),
    .rst  (rst),
    .clr  (pclr),
    .en   (busy),
    .div  (prescale_r),
    .step (step)
  );

  always_comb begin
    state_d = state;
    count_d = count;
    tick_d  = 1'b0;
    half_d  = 1'b0;
    done_d  = 1'b0;
    load    = 1'b0;
    pclr    = 1'b0;
    if (stop) begin
      // stop outranks a simultaneous start; in IDLE it is a no-op
      if (state == TMR_RUN) begin
        state_d = TMR_IDLE;
        count_d = '0;
        pclr    = 1'b1;
      end
    end else if (start) begin
      state_d = TMR_RUN;
      count_d = '0;
      pclr    = 1'b1;
      load    = 1'b1;
    end else if (state == TMR_RUN && step) begin
      half_d = ({1'b0, count} == half_pt) && (p_full != (WIDTH+1)'(1));
      if (count == last) begin
        count_d = '0;
        tick_d  = 1'b1;
        if (mode_r == TMR_ONESHOT) begin
          done_d  = 1'b1;
          state_d = TMR_IDLE;
        end
      end else begin
        count_d = count + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= TMR_IDLE;
      count      <= '0;
      tick       <= 1'b0;
      half_tick  <= 1'b0;
      done       <= 1'b0;
      period_r   <= '0;
      prescale_r <= '0;
      mode_r     <= TMR_PERIODIC;
    end else begin
      state     <= state_d;
      count     <= count_d;
      tick      <= tick_d;
      half_tick <= half_d;
      done      <= done_d;
      if (load) begin
        period_r   <= period;
        prescale_r <= prescale;
        mode_r     <= mode;
      end
    end
  end
endmodule

// File: tb/tb_uart_bit_timer.sv
// Bench for uart_bit_timer: arithmetic event-time model vs DUT, fixed and random configs.
module tb_uart_bit_timer;
  import uart_pkg::*;
  localparam int W  = 4;
  localparam int PW = 3;

  typedef logic [W+3:0] obs_t;  // {busy, tick, half_tick, done, count}

  logic clk = 1'b0;
  logic rst, start, stop;
  timer_mode_e mode;
  logic [W-1:0]  period;
  logic [PW-1:0] prescale;
  logic busy, tick, half_tick, done;
  logic [W-1:0] count;
  obs_t obs;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;
  assign obs = {busy, tick, half_tick, done, count};

  uart_bit_timer #(.WIDTH(W), .PRE_W(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .period(period), .prescale(prescale), .busy(busy), .tick(tick),
    .half_tick(half_tick), .done(done), .count(count)
  );

  // Expected outputs n edges after the edge that sampled start.
  // Step m lands on edge m*d; tick on every P-th step, half on the step leaving count H.
  function automatic obs_t mdl(int n, int p, int pre, bit os);
    int P = (p == 0) ? (1 << W) : p;
    int d = pre + 1;
    int m = n / d;
    bit stp = (n % d == 0) && (n > 0);
    logic b = 1'b1, t, h, dn = 1'b0;
    t = stp && ((m - 1) % P == P - 1);
    h = stp && (P != 1) && ((m - 1) % P == P / 2);
    if (os) begin
      if (n > P * d) return '0;
      if (n == P * d) begin b = 1'b0; dn = 1'b1; end
    end
    return {b, t, h, dn, W'(m % P)};
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Pulse start for one edge, then scramble config to show it is only sampled with start.
  task automatic do_start(int p, int pre, bit os);
    period = W'(p); prescale = PW'(pre); mode = timer_mode_e'(os);
    start = 1'b1;
    cyc();
    start = 1'b0;
    period = W'($urandom); prescale = PW'($urandom);
    mode = timer_mode_e'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; stop = 1'b0;
    period = 4'd3; prescale = '0; mode = TMR_PERIODIC;
    cyc(); cyc();
    n_tests++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset: got %b want %b", obs, obs_t'(0)); end
    rst = 1'b0; start = 1'b0;
    cyc();
    n_tests++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_idle: got %b want %b", obs, obs_t'(0)); end
  endtask

  task automatic test_periodic();
    int cfg[3][2] = '{'{4, 0}, '{3, 2}, '{7, 1}};
    for (int i = 0; i < 3; i++) begin
      do_start(cfg[i][0], cfg[i][1], 1'b0);
      for (int n = 0; n <= 3 * cfg[i][0] * (cfg[i][1] + 1) + 2; n++) begin
        if (n > 0) cyc();
        n_tests++;
        if (obs !== mdl(n, cfg[i][0], cfg[i][1], 1'b0)) begin
          n_fail++;
          $display("FAIL periodic p=%0d pre=%0d n=%0d: got %b want %b", cfg[i][0], cfg[i][1], n, obs, mdl(n, cfg[i][0], cfg[i][1], 1'b0));
        end
      end
    end
  endtask

  task automatic test_oneshot();
    int cfg[3][2] = '{'{5, 0}, '{2, 1}, '{6, 3}};
    for (int i = 0; i < 3; i++) begin
      do_start(cfg[i][0], cfg[i][1], 1'b1);
      for (int n = 0; n <= cfg[i][0] * (cfg[i][1] + 1) + 20; n++) begin
        if (n > 0) cyc();
        n_tests++;
        if (obs !== mdl(n, cfg[i][0], cfg[i][1], 1'b1)) begin
          n_fail++;
          $display("FAIL oneshot p=%0d pre=%0d n=%0d: got %b want %b", cfg[i][0], cfg[i][1], n, obs, mdl(n, cfg[i][0], cfg[i][1], 1'b1));
        end
      end
    end
  endtask

  task automatic test_edge_periods();
    int cfg[3] = '{1, 0, 2};
    for (int i = 0; i < 3; i++) begin
      do_start(cfg[i], 0, 1'b0);
      for (int n = 0; n <= 40; n++) begin
        if (n > 0) cyc();
        n_tests++;
        if (obs !== mdl(n, cfg[i], 0, 1'b0)) begin
          n_fail++;
          $display("FAIL edge_period p=%0d n=%0d: got %b want %b", cfg[i], n, obs, mdl(n, cfg[i], 0, 1'b0));
        end
      end
    end
  endtask

  // Restart mid-period, then again on the edge where a tick would have fired.
  task automatic test_restart();
    int lim[3] = '{5, 7, 20};
    for (int r = 0; r < 3; r++) begin
      do_start(8, 0, 1'b0);
      for (int n = 0; n <= lim[r]; n++) begin
        if (n > 0) cyc();
        n_tests++;
        if (obs !== mdl(n, 8, 0, 1'b0)) begin
          n_fail++;
          $display("FAIL restart r=%0d n=%0d: got %b want %b", r, n, obs, mdl(n, 8, 0, 1'b0));
        end
      end
    end
  endtask

  task automatic test_stop();
    do_start(8, 0, 1'b0);
    for (int n = 1; n <= 7; n++) cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    for (int n = 0; n < 5; n++) begin
      if (n > 0) cyc();
      n_tests++;
      if (obs !== '0) begin n_fail++; $display("FAIL stop_on_tick n=%0d: got %b want %b", n, obs, obs_t'(0)); end
    end
    stop = 1'b1;  // stop while idle: nothing happens
    cyc();
    stop = 1'b0;
    n_tests++;
    if (obs !== '0) begin n_fail++; $display("FAIL stop_idle: got %b want %b", obs, obs_t'(0)); end
  endtask

  task automatic test_stop_start();
    do_start(5, 1, 1'b0);
    cyc(); cyc(); cyc();
    stop = 1'b1; start = 1'b1; period = 4'd3; prescale = '0; mode = TMR_PERIODIC;
    cyc();
    stop = 1'b0; start = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (n > 0) cyc();
      n_tests++;
      if (obs !== '0) begin n_fail++; $display("FAIL stop_start n=%0d: got %b want %b", n, obs, obs_t'(0)); end
    end
  endtask

  task automatic test_reset_midrun();
    do_start(8, 3, 1'b0);
    for (int n = 1; n <= 10; n++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_tests++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_midrun: got %b want %b", obs, obs_t'(0)); end
    do_start(8, 3, 1'b0);
    for (int n = 0; n <= 70; n++) begin
      if (n > 0) cyc();
      n_tests++;
      if (obs !== mdl(n, 8, 3, 1'b0)) begin
        n_fail++;
        $display("FAIL after_reset n=%0d: got %b want %b", n, obs, mdl(n, 8, 3, 1'b0));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      int p   = $urandom_range(0, (1 << W) - 1);
      int pre = $urandom_range(0, (1 << PW) - 1);
      bit os  = 1'($urandom_range(0, 1));
      int pf  = (p == 0) ? (1 << W) : p;
      do_start(p, pre, os);
      for (int n = 0; n <= 2 * pf * (pre + 1) + 3; n++) begin
        if (n > 0) cyc();
        n_tests++;
        if (obs !== mdl(n, p, pre, os)) begin
          n_fail++;
          $display("FAIL random p=%0d pre=%0d os=%0d n=%0d: got %b want %b", p, pre, os, n, obs, mdl(n, p, pre, os));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_edge_periods();
    test_restart();
    test_stop();
    test_stop_start();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
